// File: rtl/serdes_pkg.sv
// Shared serializer/deserializer definitions: parameter legality, test pattern
// and lane helpers operating on maximum-width containers.
package serdes_pkg;

    localparam int MAX_W     = 16;
    localparam int MAX_BUS_W = 256;

    typedef logic [MAX_W-1:0]     word_t;
    typedef logic [MAX_BUS_W-1:0] bus_t;

    function automatic bit params_legal(input int dw, input int ch, input int ddr, input int msb);
        return (dw >= 4) && (dw <= MAX_W) && ((dw % 2) == 0) && (ch >= 1) &&
               ((ch * dw) <= MAX_BUS_W) && (ddr >= 0) && (ddr <= 1) && (msb >= 0) && (msb <= 1);
    endfunction

    function automatic int period(input int dw, input int ddr);
        return (ddr != 0) ? (dw / 2) : dw;
    endfunction

    // Alternating pattern with bit 0 set, i.e. {dw/2{2'b01}}
    function automatic word_t test_pattern(input int dw);
        word_t p;
        for (int i = 0; i < MAX_W; i++) begin
            p[i] = (i < dw) ? ~i[0] : 1'b0;
        end
        return p;
    endfunction

    function automatic word_t lane_slice(input bus_t bus, input int k, input int dw);
        word_t r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = (i < dw) ? bus[k * dw + i] : 1'b0;
        end
        return r;
    endfunction

    function automatic word_t bit_reverse(input word_t w, input int dw);
        word_t r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = (i < dw) ? w[dw - 1 - i] : 1'b0;
        end
        return r;
    endfunction

    function automatic word_t even_bits(input word_t w);
        word_t r;
        r = {MAX_W{1'b0}};
        for (int i = 0; i < MAX_W / 2; i++) begin
            r[i] = w[2 * i];
        end
        return r;
    endfunction

    function automatic word_t odd_bits(input word_t w);
        word_t r;
        r = {MAX_W{1'b0}};
        for (int i = 0; i < MAX_W / 2; i++) begin
            r[i] = w[2 * i + 1];
        end
        return r;
    endfunction

endpackage

// File: rtl/ddio_out.sv
// Behavioural DDR output cell: d_hi is driven while clk is high, d_lo while clk is low.
module ddio_out #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_hi,
    input  logic d_lo,
    output logic q
);

    logic hi_q;
    logic lo_q;
    logic lo_neg_q;

    // Capture both halves on the rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= RST_VAL;
            lo_q <= RST_VAL;
        end else begin
            hi_q <= d_hi;
            lo_q <= d_lo;
        end
    end

    // Retime the low half so the output mux never switches on a changing input
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_neg_q <= RST_VAL;
        end else begin
            lo_neg_q <= lo_q;
        end
    end

    assign q = clk ? hi_q : lo_neg_q;

endmodule

// File: rtl/serializer_ddr_multi.sv
// Multi-lane parallel-to-serial converter with optional DDR output, bit slip
// and a built-in alternating test pattern.
module serializer_ddr_multi
    import serdes_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int CH_NUM    = 4,
    parameter int DDR_EN    = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                       serial_clk,
    input  logic                       sys_rst_n,
    input  logic                       en,
    input  logic                       test_mode,
    input  logic                       bit_slip,
    input  logic [CH_NUM*DATA_W-1:0]   parallel_data,
    output logic                       word_req,
    output logic                       word_load,
    output logic [CH_NUM-1:0]          serial_data_p,
    output logic [CH_NUM-1:0]          serial_data_n
);

    // Each shift register is exactly one word period long in both modes
    localparam int P     = period(DATA_W, DDR_EN);
    localparam int SR_W  = P;
    localparam int CNT_W = $clog2(P);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P - 1);
    localparam logic [CNT_W-1:0] CNT_REQ  = CNT_W'(P - 2);

    if (!params_legal(DATA_W, CH_NUM, DDR_EN, MSB_FIRST)) begin : g_bad_params
        $error("serializer_ddr_multi: illegal parameter combination");
    end

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SR_W-1:0]  rise_q [CH_NUM];
    logic [SR_W-1:0]  rise_d [CH_NUM];
    logic [SR_W-1:0]  fall_q [CH_NUM];
    logic [SR_W-1:0]  fall_d [CH_NUM];
    word_t            lane_word_s [CH_NUM];
    logic [CH_NUM-1:0] ddio_hi_s;
    logic [CH_NUM-1:0] ddio_lo_s;

    // Per-lane word in transmit order
    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            lane_word_s[k] = test_mode ? test_pattern(DATA_W)
                                       : lane_slice(bus_t'(parallel_data), k, DATA_W);
            if (MSB_FIRST != 0) begin
                lane_word_s[k] = bit_reverse(lane_word_s[k], DATA_W);
            end else begin
                lane_word_s[k] = lane_word_s[k];
            end
        end
    end

    // Handshake strobes; slip and disable both suppress them
    always_comb begin
        word_load = sys_rst_n && en && !bit_slip && (bit_cnt_q == CNT_LAST);
        word_req  = sys_rst_n && en && !bit_slip && (bit_cnt_q == CNT_REQ);
    end

    // Next-state: disable clears, slip holds, last count loads, otherwise shift
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        for (int k = 0; k < CH_NUM; k++) begin
            rise_d[k] = rise_q[k];
            fall_d[k] = fall_q[k];
        end
        if (!en) begin
            bit_cnt_d = CNT_LAST;
            for (int k = 0; k < CH_NUM; k++) begin
                rise_d[k] = {SR_W{1'b0}};
                fall_d[k] = {SR_W{1'b0}};
            end
        end else if (bit_slip) begin
            bit_cnt_d = bit_cnt_q;
        end else if (bit_cnt_q == CNT_LAST) begin
            bit_cnt_d = {CNT_W{1'b0}};
            for (int k = 0; k < CH_NUM; k++) begin
                if (DDR_EN != 0) begin
                    rise_d[k] = SR_W'(even_bits(lane_word_s[k]));
                    fall_d[k] = SR_W'(odd_bits(lane_word_s[k]));
                end else begin
                    rise_d[k] = SR_W'(lane_word_s[k]);
                    fall_d[k] = {SR_W{1'b0}};
                end
            end
        end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            for (int k = 0; k < CH_NUM; k++) begin
                rise_d[k] = {1'b0, rise_q[k][SR_W-1:1]};
                fall_d[k] = {1'b0, fall_q[k][SR_W-1:1]};
            end
        end
    end

    // State registers
    always_ff @(posedge serial_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt_q <= CNT_LAST;
            for (int k = 0; k < CH_NUM; k++) begin
                rise_q[k] <= {SR_W{1'b0}};
                fall_q[k] <= {SR_W{1'b0}};
            end
        end else begin
            bit_cnt_q <= bit_cnt_d;
            for (int k = 0; k < CH_NUM; k++) begin
                rise_q[k] <= rise_d[k];
                fall_q[k] <= fall_d[k];
            end
        end
    end

    // Gating with en makes the line idle in the cycle right after disable
    always_comb begin
        for (int k = 0; k < CH_NUM; k++) begin
            ddio_hi_s[k] = en & rise_q[k][0];
            ddio_lo_s[k] = en & ((DDR_EN != 0) ? fall_q[k][0] : rise_q[k][0]);
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
        ddio_out #(.RST_VAL(1'b0)) u_ddio_p (
            .clk   (serial_clk),
            .rst_n (sys_rst_n),
            .d_hi  (ddio_hi_s[k]),
            .d_lo  (ddio_lo_s[k]),
            .q     (serial_data_p[k])
        );
        ddio_out #(.RST_VAL(1'b1)) u_ddio_n (
            .clk   (serial_clk),
            .rst_n (sys_rst_n),
            .d_hi  (~ddio_hi_s[k]),
            .d_lo  (~ddio_lo_s[k]),
            .q     (serial_data_n[k])
        );
    end

endmodule

// File: doc/serializer_ddr_multi.md
SERIALIZER_DDR_MULTI -- requirements
Module: serializer_ddr_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 10, parallel word width per channel; even, 4..16.
REQ-002 SHALL have parameter CH_NUM, default 4, number of independent lanes.
REQ-003 SHALL have parameter DDR_EN, default 1: 1 = two bits per clock via DDIO; 0 = one bit per clock, rising edge only.
REQ-004 SHALL have parameter MSB_FIRST, default 0: 0 = bit 0 transmitted first; 1 = bit DATA_W-1 first.
REQ-005 serial_clk  input  1  serial bit clock; the single clock of the block.
REQ-006 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 en  input  1  serialisation enable.
REQ-008 test_mode  input  1  1 = transmit built-in pattern instead of parallel_data.
REQ-009 bit_slip  input  1  one-cycle pulse; delays word boundary by one serial_clk cycle.
REQ-010 parallel_data  input  CH_NUM*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
REQ-011 word_req  output  1  pulse one cycle before a word is captured.
REQ-012 word_load  output  1  pulse in the cycle parallel_data is captured.
REQ-013 serial_data_p  output  CH_NUM  per-lane serial output, true polarity.
REQ-014 serial_data_n  output  CH_NUM  per-lane serial output, complement.

Function
REQ-015 Period P SHALL be DATA_W/2 when DDR_EN=1, else DATA_W.
REQ-016 Counter bit_cnt SHALL count 0..P-1 and wrap to 0; word_load=1 when en=1 and bit_cnt==P-1; word_req=1 when en=1 and bit_cnt==P-2.
REQ-017 On word_load, each lane's shift registers SHALL capture its parallel_data lane in that same cycle; first bit appears on the DDIO input in the next cycle.
REQ-018 DDR_EN=1, MSB_FIRST=0: rise register SHALL hold bits {DATA_W-2..4,2,0}, fall register {DATA_W-1..5,3,1}; both shift right each non-load cycle; bit[0] of each drives DDIO high/low inputs.
REQ-019 MSB_FIRST=1 SHALL bit-reverse the lane word before REQ-018/REQ-020 mapping.
REQ-020 DDR_EN=0: single DATA_W shift register SHALL shift right one bit per cycle; bit[0] drives both DDIO high and low inputs.
REQ-021 Non-load cycles SHALL shift in zeros.
REQ-022 serial_data_n SHALL be the bitwise complement of serial_data_p at every edge (driven via separate DDIO with inverted inputs).
REQ-023 test_mode=1 at word_load SHALL capture pattern {DATA_W/2{2'b01}} in every lane instead of parallel_data; test_mode changes take effect only at the next word_load.
REQ-024 bit_slip=1 with en=1 SHALL hold bit_cnt and all shift registers for that cycle (current bit repeated once); word_req/word_load suppressed that cycle.
REQ-025 bit_slip coinciding with bit_cnt==P-1 SHALL win: load deferred exactly one cycle.
REQ-026 bit_slip on N consecutive cycles SHALL hold for N cycles.
REQ-027 en=0 SHALL force bit_cnt to P-1, clear shift registers, and hold word_req/word_load low; the first cycle with en=1 SHALL be a word_load cycle.
REQ-028 bit_slip SHALL be ignored while en=0.

Reset
REQ-029 sys_rst_n=0 SHALL asynchronously set bit_cnt to P-1 and all shift registers to 0; word_req=0, word_load=0.
REQ-030 After reset, serial_data_p SHALL be 0 and serial_data_n 1 from the first serial_clk edge onward until a word is loaded.
REQ-031 Reset asserted mid-word SHALL abandon the word; no partial word resumes after release.

Structure
REQ-032 Parameter legality checks, test pattern and lane-slice helper SHALL reside in package serdes_pkg shared with future deserializer work.
REQ-033 The existing ddio_out primitive wrapper SHALL be the single sub-module, instantiated 2*CH_NUM times (p and n per lane); all other logic is flat.

Verification
REQ-034 Defaults, lane0=10'h2AA, en held 1 -> word_load every 5 cycles; serial_data_p[0] bit stream 0,1,0,1,... LSB first.
REQ-035 MSB_FIRST=1, lane1=10'h001 -> single 1 appears as the last (10th) bit of the word on serial_data_p[1]; serial_data_n[1] complements every bit.
REQ-036 DDR_EN=0, DATA_W=8, word 8'hC3 -> word_load period 8 cycles; output 1,1,0,0,0,0,1,1.
REQ-037 bit_slip pulse at bit_cnt==4 -> word_load delayed to 6 cycles after previous; one bit repeated; subsequent period returns to 5.
REQ-038 test_mode=1 -> all lanes output alternating 1,0 regardless of parallel_data; en=0 mid-word -> outputs p=0/n=1 next cycle, word_load on first cycle after en=1.
REQ-039 sys_rst_n asserted mid-word, released -> word_req/word_load 0, p=0/n=1, word_load on the first cycle after release with en=1.
